// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with single-cycle logic/shift/add ops, iterative
// multiply (and optional divide) behind a valid/ready handshake, plus the
// O|S|Z|C flags register.
// Build option: define ALU_SEQ_DIV_EN to include the DIV state and ops 20/21;
// without it, ops 20/21 are illegal (result 0, flags unchanged).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] s_1,
  input  logic [WIDTH-1:0] s_2,
  input  logic             flag_we,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int W1 = WIDTH + 1;

`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, acc_hi, acc_lo;
  logic             op_alt, fwe_q;
  logic             c_q, is_mul, is_div, accept, last, slot_free, finish;

  assign c_q       = flags[0];
  assign is_mul    = (alu_op == 5'd18) | (alu_op == 5'd19);
`ifdef ALU_SEQ_DIV_EN
  assign is_div    = (alu_op == 5'd20) | (alu_op == 5'd21);
`else
  assign is_div    = 1'b0;
`endif
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == S_IDLE) && slot_free;
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready && !kill;
  assign last      = busy && (cnt == '0);
  assign finish    = last && slot_free;

  // ---- shifter: amounts past WIDTH+1 clamp, everything is shifted out by then
  logic             amt_zero, lin, rin, rfill;
  logic [7:0]       sh;
  logic [WIDTH:0]   shl_v, shr_v;
  logic [WIDTH-1:0] rmod, rotl_res, rotr_res;

  assign amt_zero = (s_2 == '0);
  assign sh       = (s_2 > WIDTH'(WIDTH + 1)) ? 8'(WIDTH + 1) : 8'(s_2 - WIDTH'(1));
  assign lin      = (alu_op == 5'd12) & c_q;
  assign rfill    = (alu_op == 5'd9) & s_1[WIDTH-1];
  assign rin      = (alu_op == 5'd13) ? c_q : rfill;
  // shl_v[WIDTH] is the last bit out; shr_v[0] is the last bit out
  assign shl_v    = W1'({{W1{1'b0}}, s_1, lin} << sh);
  assign shr_v    = W1'({{W1{rfill}}, rin, s_1} >> sh);
  assign rmod     = s_2 % WIDTH'(WIDTH);
  assign rotl_res = WIDTH'({s_1, s_1} >> (WIDTH'(WIDTH) - rmod));
  assign rotr_res = WIDTH'({s_1, s_1} >> rmod);

  // ---- adder: sub/subb invert s_2, carry-in is 1 for sub and C for addc/subb
  logic [WIDTH-1:0] add_b;
  logic             add_cin, add_ovf;
  logic [WIDTH:0]   add_sum;

  assign add_b   = (alu_op >= 5'd16) ? ~s_2 : s_2;
  assign add_cin = alu_op[0] ? c_q : (alu_op == 5'd16);
  assign add_sum = {1'b0, s_1} + {1'b0, add_b} + W1'(add_cin);
  assign add_ovf = (s_1[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != s_1[WIDTH-1]);

  // Single-cycle result and carry/overflow; illegal codes leave flags alone
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_o, sc_legal;
  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_o     = 1'b0;
    sc_legal = 1'b1;
    case (alu_op)
      5'd0:  sc_res = s_1 & s_2;
      5'd1:  sc_res = ~(s_1 & s_2);
      5'd2:  sc_res = s_1 | s_2;
      5'd3:  sc_res = ~(s_1 | s_2);
      5'd4:  sc_res = s_1 ^ s_2;
      5'd5:  sc_res = ~(s_1 ^ s_2);
      5'd6:  sc_res = ~s_2;
      5'd7, 5'd12: begin sc_res = shl_v[WIDTH-1:0]; sc_c = shl_v[WIDTH]; end
      5'd8, 5'd9, 5'd13: begin sc_res = shr_v[WIDTH:1]; sc_c = shr_v[0]; end
      5'd10: begin sc_res = rotl_res; sc_c = rotl_res[0]; end
      5'd11: begin sc_res = rotr_res; sc_c = rotr_res[WIDTH-1]; end
      5'd14, 5'd15, 5'd16, 5'd17: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_o   = add_ovf;
      end
      default: sc_legal = 1'b0;
    endcase
    if ((alu_op >= 5'd7) && (alu_op <= 5'd13) && amt_zero) begin
      sc_res = s_1;
      sc_c   = c_q;
    end
  end

  // ---- iterative datapath: mul keeps {hi,lo} product with multiplier in lo;
  // div keeps remainder in hi and shifts quotient bits into lo
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo, mc_res;
  logic             mc_o;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_part;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign div_part = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = (div_part >= {1'b0, opa});
  assign div_diff = WIDTH'(div_part - {1'b0, opa});
`endif

  // One iteration of the active multi-cycle op, plus its final result/overflow
  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    mc_o    = !op_alt && (step_hi != '0);
`ifdef ALU_SEQ_DIV_EN
    if (state == S_DIV) begin
      step_hi = div_ge ? div_diff : div_part[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
      mc_o    = (opa == '0);
    end
`endif
    mc_res = op_alt ? step_hi : step_lo;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state: kill wins, multi-cycle ops leave IDLE, finish returns
  always_comb begin
    state_nx = state;
    if (kill) state_nx = S_IDLE;
    else if (state == S_IDLE) begin
      if (accept && is_mul) state_nx = S_MUL;
`ifdef ALU_SEQ_DIV_EN
      else if (accept && is_div) state_nx = S_DIV;
`endif
    end else if (finish) state_nx = S_IDLE;
  end

  // Operand latch and iteration; the final step holds while the slot is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; opa <= '0; acc_hi <= '0; acc_lo <= '0; op_alt <= 1'b0; fwe_q <= 1'b0;
    end else if (!kill) begin
      if (accept && (is_mul || is_div)) begin
        opa    <= is_mul ? s_1 : s_2;
        acc_hi <= '0;
        acc_lo <= is_mul ? s_2 : s_1;
        cnt    <= CW'(WIDTH - 1);
        op_alt <= alu_op[0];
        fwe_q  <= flag_we;
      end else if (busy && !(last && !slot_free)) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

  // Output register, valid bit and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0; out_valid <= 1'b0; flags <= 4'b0000;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (accept && !is_mul && !is_div) begin
      result    <= sc_res;
      out_valid <= 1'b1;
      if (flag_we && sc_legal) flags <= {sc_o, sc_res[WIDTH-1], (sc_res == '0), sc_c};
    end else if (finish) begin
      result    <= mc_res;
      out_valid <= 1'b1;
      if (fwe_q) flags <= {mc_o, mc_res[WIDTH-1], (mc_res == '0), 1'b0};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=32.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, flag_we = 1'b0, kill = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [4:0]   alu_op = '0;
  logic [W-1:0] s_1 = '0, s_2 = '0, result;
  logic [3:0]   flags;
  int           n_vec = 0, n_err = 0;
  logic [3:0]   ef = 4'b0000;

  typedef struct { logic [W-1:0] res; logic [3:0] flg; logic [3:0] fmask; } exp_t;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .s_1(s_1), .s_2(s_2), .flag_we(flag_we), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  // offer one op at the current negedge; returns at the negedge after the accept edge
  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic fwe);
    alu_op = op; s_1 = a; s_2 = b; flag_we = fwe; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] r, input logic [3:0] f, input logic [3:0] m);
    exp_t e;
    e.res = r; e.flg = f; e.fmask = m;
    sb.push_back(e);
    if (m == 4'hF) ef = f;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    exp_t e;
    #2 rst_n = 1'b0;
    #1 n_vec++;
    if (out_valid !== 1'b0 || flags !== 4'b0000 || busy !== 1'b0 || result !== '0) begin
      n_err++; $display("FAIL reset_init: valid=%b flags=%b busy=%b result=%h, want 0 0000 0 0", out_valid, flags, busy, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready); end
    push(32'h0, 4'b0011, 4'hF);
    drive(5'd14, 32'hFFFF_FFFF, 32'h1, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL reset_pre_add: valid=%b result=%h flags=%b, want 1 %h %b", out_valid, result, flags, e.res, e.flg);
    end
    drive(5'd18, 32'd3, 32'd5, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 n_vec++;
    if (out_valid !== 1'b0 || flags !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_mul: valid=%b flags=%b busy=%b, want 0 0000 0", out_valid, flags, busy);
    end
    ef = 4'b0000;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_add_carry();
    exp_t e;
    push(32'h0, 4'b0011, 4'hF);
    drive(5'd14, 32'hFFFF_FFFF, 32'h1, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL add: valid=%b result=%h flags=%b, want 1 %h %b", out_valid, result, flags, e.res, e.flg);
    end
    push(32'h1, 4'b0000, 4'hF);
    drive(5'd15, 32'h0, 32'h0, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL addc: valid=%b result=%h flags=%b, want 1 %h %b", out_valid, result, flags, e.res, e.flg);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [4:0]   op [6] = '{5'd16, 5'd13, 5'd9, 5'd11, 5'd7, 5'd7};
    logic [W-1:0] a  [6] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h1, 32'h5, 32'h8000_0001};
    logic [W-1:0] b  [6] = '{32'h1, 32'd4, 32'd32, 32'd33, 32'd0, 32'd40};
    logic [W-1:0] r  [6] = '{32'h7FFF_FFFF, 32'h1000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'h0};
    logic [3:0]   f  [6] = '{4'b1001, 4'b0000, 4'b0101, 4'b0101, 4'b0001, 4'b0010};
    logic [3:0]   m  [6] = '{4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};
    for (int i = 0; i < 6; i++) begin
      push(r[i], f[i], m[i]);
      drive(op[i], a[i], b[i], 1'b1);
      e = sb.pop_front(); n_vec++;
      if (out_valid !== 1'b1 || result !== e.res || (flags & e.fmask) !== (e.flg & e.fmask)) begin
        n_err++; $display("FAIL shift_ovf[%0d] op=%0d: result=%h flags=%b, want %h %b (mask %b)", i, op[i], result, flags, e.res, e.flg, e.fmask);
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int cyc;
    push(32'h0, 4'b1010, 4'hF);
    drive(5'd18, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_out(cyc);
    n_vec++;
    if (cyc != 32) begin n_err++; $display("FAIL mul_latency: out_valid after %0d cycles, want 32", cyc); end
    e = sb.pop_front(); n_vec++;
    if (result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL mul: result=%h flags=%b, want %h %b", result, flags, e.res, e.flg);
    end
    push(32'h1, 4'b0000, 4'hF);
    drive(5'd19, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_out(cyc);
    e = sb.pop_front(); n_vec++;
    if (cyc != 32 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL mulhu: cycles=%0d result=%h flags=%b, want 32 %h %b", cyc, result, flags, e.res, e.flg);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int cyc;
    push(32'd15, 4'b0000, 4'hF);
    drive(5'd18, 32'd3, 32'd5, 1'b1);
    out_ready = 1'b0;
    wait_out(cyc);
    e = sb.pop_front(); n_vec++;
    if (cyc != 32 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL hold_mul: cycles=%0d result=%h flags=%b, want 32 %h %b", cyc, result, flags, e.res, e.flg);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); n_vec++;
      if (out_valid !== 1'b1 || result !== e.res || in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d]: valid=%b result=%h in_ready=%b, want 1 %h 0", i, out_valid, result, in_ready, e.res);
      end
    end
    out_ready = 1'b1;
    @(negedge clk); n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_div();
    exp_t e;
    int cyc;
`ifdef ALU_SEQ_DIV_EN
    logic [4:0]   op [4] = '{5'd20, 5'd21, 5'd20, 5'd21};
    logic [W-1:0] a  [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [W-1:0] b  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] r  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    logic [3:0]   f  [4] = '{4'b0000, 4'b0000, 4'b1100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      push(r[i], f[i], 4'hF);
      drive(op[i], a[i], b[i], 1'b1);
      wait_out(cyc);
      e = sb.pop_front(); n_vec++;
      if (cyc != 32 || result !== e.res || flags !== e.flg) begin
        n_err++; $display("FAIL div[%0d]: cycles=%0d result=%h flags=%b, want 32 %h %b", i, cyc, result, flags, e.res, e.flg);
      end
    end
`else
    push(32'h0, 4'b0011, 4'hF);
    drive(5'd14, 32'hFFFF_FFFF, 32'h1, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL div_pre_add: result=%h flags=%b, want %h %b", result, flags, e.res, e.flg);
    end
    push(32'h0, ef, 4'hF);
    drive(5'd20, 32'd100, 32'd7, 1'b1);
    cyc = 0;
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL divu_disabled: valid=%b busy=%b result=%h flags=%b, want 1 0 %h %b", out_valid, busy, result, flags, e.res, e.flg);
    end
`endif
  endtask

  task automatic test_illegal();
    exp_t e;
    push(32'h0, ef, 4'hF);
    drive(5'd25, 32'd123, 32'd456, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL illegal: valid=%b result=%h flags=%b, want 1 %h %b", out_valid, result, flags, e.res, e.flg);
    end
  endtask

  task automatic test_kill();
    exp_t e;
    push(32'h0, 4'b0011, 4'hF);
    drive(5'd14, 32'hFFFF_FFFF, 32'h1, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL kill_pre_add: result=%h flags=%b, want %h %b", result, flags, e.res, e.flg);
    end
    drive(5'd18, 32'd3, 32'd5, 1'b1);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk); n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || flags !== ef) begin
      n_err++; $display("FAIL kill: busy=%b valid=%b flags=%b, want 0 0 %b", busy, out_valid, flags, ef);
    end
    push(32'h0000_000F, 4'b0000, 4'hF);
    drive(5'd4, 32'h0000_00F0, 32'h0000_00FF, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_err++; $display("FAIL kill_next_op: valid=%b result=%h flags=%b, want 1 %h %b", out_valid, result, flags, e.res, e.flg);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0]   opc [5] = '{5'd0, 5'd2, 5'd4, 5'd14, 5'd16};
    logic [2:0]   k;
    logic [W-1:0] a, b, r;
    logic [W:0]   s;
    logic         fwe, o, c;
    for (int i = 0; i < 12; i++) begin
      k = 3'($urandom_range(0, 4));
      a = $urandom; b = $urandom;
      if (i % 3 == 0) b = (k == 3'd3) ? (~a + 32'd1) : a;
      fwe = 1'($urandom_range(0, 1));
      o = 1'b0; c = 1'b0;
      case (k)
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a ^ b;
        3'd3: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; o = (a[31] == b[31]) && (r[31] != a[31]); end
        default: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[W-1:0]; c = s[W]; o = (a[31] != b[31]) && (r[31] != a[31]); end
      endcase
      push(r, fwe ? {o, r[31], (r == '0), c} : ef, 4'hF);
      alu_op = opc[k]; s_1 = a; s_2 = b; flag_we = fwe; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      e = sb.pop_front(); n_vec++;
      if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
        n_err++; $display("FAIL b2b[%0d] op=%0d: valid=%b result=%h flags=%b, want 1 %h %b", i, opc[k], out_valid, result, flags, e.res, e.flg);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_overflow();
    test_mul();
    test_hold();
    test_div();
    test_illegal();
    test_kill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
